id_ex_pipe_reg: RTL and testbench

Decode-to-execute pipeline register of the pipelined RV32I core. It sits directly downstream of the control unit and register file. Each cycle it captures the decoded control bundle, the register operands, the immediate, the PC values and the register indices, and presents them to the execute stage. It supports hold (stall) and synchronous flush (bubble insertion) driven by the hazard unit, and tracks a valid bit per slot.

---
 rtl/id_ex_pipe_reg.sv | 115 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall, flush and per-slot valid tracking.
// Invalid slots are captured with their side-effecting controls cleared, so they act as bubbles.
module id_ex_pipe_reg #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } slot_t;

  slot_t slot_next;
  slot_t slot_reg;

  // Gate only the controls that change architectural state or redirect the PC.
  always_comb begin
    slot_next             = '0;
    slot_next.valid       = ValidD;
    slot_next.reg_write   = RegWriteD & ValidD;
    slot_next.mem_write   = MemWriteD & ValidD;
    slot_next.jump        = JumpD & ValidD;
    slot_next.branch      = BranchD & ValidD;
    slot_next.alu_src     = ALUSrcD;
    slot_next.result_src  = ResultSrcD;
    slot_next.alu_control = ALUControlD;
    slot_next.rd1         = RD1D;
    slot_next.rd2         = RD2D;
    slot_next.imm_ext     = ImmExtD;
    slot_next.pc          = PCD;
    slot_next.pc_plus4    = PCPlus4D;
    slot_next.rs1         = Rs1D;
    slot_next.rs2         = Rs2D;
    slot_next.rd          = RdD;
  end

  // Flush takes priority over stall.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      slot_reg <= '0;
    end else if (FlushE) begin
      slot_reg <= '0;
    end else if (!StallE) begin
      slot_reg <= slot_next;
    end
  end

  assign ValidE      = slot_reg.valid;
  assign RegWriteE   = slot_reg.reg_write;
  assign MemWriteE   = slot_reg.mem_write;
  assign JumpE       = slot_reg.jump;
  assign BranchE     = slot_reg.branch;
  assign ALUSrcE     = slot_reg.alu_src;
  assign ResultSrcE  = slot_reg.result_src;
  assign ALUControlE = slot_reg.alu_control;
  assign RD1E        = slot_reg.rd1;
  assign RD2E        = slot_reg.rd2;
  assign ImmExtE     = slot_reg.imm_ext;
  assign PCE         = slot_reg.pc;
  assign PCPlus4E    = slot_reg.pc_plus4;
  assign Rs1E        = slot_reg.rs1;
  assign Rs2E        = slot_reg.rs2;
  assign RdE         = slot_reg.rd;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios followed by randomized
// traffic with stalls, flushes, invalid slots and asynchronous reset pulses.
module tb_id_ex_pipe_reg;
  localparam int XLEN = 32;
  localparam int W = 186;

  logic CLK = 1'b0;
  logic RST;
  logic StallE, FlushE, ValidD;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] model;

  id_ex_pipe_reg #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RST(RST), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
            RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};
  endfunction

  // What an execute stage should see for the currently presented decode slot.
  function automatic logic [W-1:0] decoded_slot();
    logic side_ok;
    side_ok = ValidD;
    return {ValidD, RegWriteD && side_ok, MemWriteD && side_ok, JumpD && side_ok,
            BranchD && side_ok, ALUSrcD, ResultSrcD, ALUControlD,
            RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};
  endfunction

  task automatic drive_all(input logic [31:0] v);
    ValidD = v[0]; RegWriteD = v[0]; MemWriteD = v[0]; JumpD = v[0]; BranchD = v[0];
    ALUSrcD = v[0]; ResultSrcD = v[1:0]; ALUControlD = v[2:0];
    RD1D = v; RD2D = v; ImmExtD = v; PCD = v; PCPlus4D = v;
    Rs1D = v[4:0]; Rs2D = v[4:0]; RdD = v[4:0];
  endtask

  task automatic randomize_inputs();
    ValidD = ($urandom_range(0, 9) < 8); RegWriteD = $urandom; MemWriteD = $urandom;
    JumpD = $urandom; BranchD = $urandom; ALUSrcD = $urandom;
    ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
    PCPlus4D = PCD + 32'd4; Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
  endtask

  // One clock edge: update the reference from the values present at the edge, then compare.
  task automatic step(input string tag);
    @(posedge CLK);
    if (RST) begin
      if (FlushE) model = '0;
      else if (!StallE) model = decoded_slot();
    end else begin
      model = '0;
    end
    #1;
    check_eq(tag, 256'(observed()), 256'(model));
  endtask

  initial begin
    RST = 1'b0; StallE = 1'b0; FlushE = 1'b0; model = '0;
    drive_all(32'hFFFF_FFFF);
    #2;
    check_eq("reset_all_zero", 256'(observed()), 256'(0));
    @(negedge CLK); RST = 1'b1;
    step("reset_release_capture");
    check_eq("reset_rd1e", 256'(RD1E), 256'(32'hFFFF_FFFF));
    check_eq("reset_regwritee", 256'(RegWriteE), 256'(1));

    drive_all(32'h0);
    ValidD = 1'b1; RD1D = 32'h0000_1234; ImmExtD = 32'hFFFF_FFF0; RdD = 5'd5;
    ALUControlD = 3'b010;
    #1;
    check_eq("pass_not_before", 256'(RD1E), 256'(32'hFFFF_FFFF));
    step("pass_through");
    check_eq("pass_rd1e", 256'(RD1E), 256'(32'h0000_1234));
    check_eq("pass_immexte", 256'(ImmExtE), 256'(32'hFFFF_FFF0));
    check_eq("pass_rde", 256'(RdE), 256'(5));
    check_eq("pass_aluctl", 256'(ALUControlE), 256'(3'b010));

    PCD = 32'h100;
    step("stall_capture");
    PCD = 32'h104; StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall_hold");
      check_eq("stall_pce", 256'(PCE), 256'(32'h100));
    end
    StallE = 1'b0;
    step("stall_release");
    check_eq("stall_release_pce", 256'(PCE), 256'(32'h104));

    StallE = 1'b1; FlushE = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1;
    step("flush_priority");
    check_eq("flush_all_zero", 256'(observed()), 256'(0));
    check_eq("flush_valide", 256'(ValidE), 256'(0));
    StallE = 1'b0; FlushE = 1'b0;

    ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; RD2D = 32'hA5A5_A5A5;
    step("invalid_slot");
    check_eq("invalid_ctrl", 256'({RegWriteE, MemWriteE, JumpE}), 256'(0));
    check_eq("invalid_rd2e", 256'(RD2E), 256'(32'hA5A5_A5A5));

    ValidD = 1'b1; PCD = 32'h200;
    step("arst_capture");
    StallE = 1'b1; PCD = 32'h204;
    step("arst_stall");
    check_eq("arst_pce_held", 256'(PCE), 256'(32'h200));
    #2 RST = 1'b0;
    #1;
    model = '0;
    check_eq("arst_pce_zero", 256'(PCE), 256'(0));
    check_eq("arst_all_zero", 256'(observed()), 256'(0));
    #2 RST = 1'b1; StallE = 1'b0;
    step("arst_resume");
    check_eq("arst_resume_pce", 256'(PCE), 256'(32'h204));

    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 4) == 0) begin
        // Mid-cycle glitch: the values present at the edge are all that matter.
        #2 randomize_inputs();
      end
      if ($urandom_range(0, 19) == 0) begin
        #1 RST = 1'b0;
        #1;
        model = '0;
        check_eq("rand_arst", 256'(observed()), 256'(0));
        RST = 1'b1;
      end
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
